pong_match_engine: RTL and testbench

- Single-clock-domain Pong game engine; successor to the fixed two-paddle position controller.
- Adds parametrised paddle and ball speeds, ball velocity with wall and paddle bounces, per-player scoring, a serve delay, and a win/game-over state machine.
- Sits in the slow game domain; its position, score and state outputs feed the existing domain handshake and the graphics driver.

---
 rtl/pong_match_engine_if.sv | 34 +++
 rtl/pong_match_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_pong_match_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_engine_if.sv
// Player inputs and game-state outputs of the Pong match engine.
// The engine takes the slave modport; the driving side takes master.
interface pong_match_engine_if #(
    parameter int HW = 9,
    parameter int WW = 10,
    parameter int SW = 3
);
    logic          button_up_1;
    logic          button_down_1;
    logic          button_up_2;
    logic          button_down_2;
    logic          start;
    logic [HW-1:0] paddle_1_pos;
    logic [HW-1:0] paddle_2_pos;
    logic [WW-1:0] ball_pos_x;
    logic [HW-1:0] ball_pos_y;
    logic [SW-1:0] score_1;
    logic [SW-1:0] score_2;
    logic [1:0]    game_state;
    logic          winner;
    logic          tick;

    modport slave (
        input  button_up_1, button_down_1, button_up_2, button_down_2, start,
        output paddle_1_pos, paddle_2_pos, ball_pos_x, ball_pos_y,
               score_1, score_2, game_state, winner, tick
    );

    modport master (
        output button_up_1, button_down_1, button_up_2, button_down_2, start,
        input  paddle_1_pos, paddle_2_pos, ball_pos_x, ball_pos_y,
               score_1, score_2, game_state, winner, tick
    );
endinterface

// File: rtl/pong_match_engine.sv
// Pong game engine: paddles, ball with wall/paddle bounces, scoring,
// serve delay and win detection, all advanced on a slow movement tick.
module pong_match_engine #(
    parameter int POSITION_CHANGE_FREQ_IN_CLOCKS = 1000,
    parameter int TOTAL_WIDTH                    = 640,
    parameter int TOTAL_HEIGHT                   = 480,
    parameter int PADDLE_DISTANCE_FROM_EDGE      = 20,
    parameter int PADDLE_HEIGHT                  = 64,
    parameter int PADDLE_WIDTH                   = 8,
    parameter int BALL_SIDE_SIZE                 = 8,
    parameter int PADDLE_SPEED                   = 2,
    parameter int BALL_SPEED                     = 1,
    parameter int WIN_SCORE                      = 7,
    parameter int SERVE_DELAY_TICKS              = 100
) (
    input  logic clk,
    input  logic rst,
    pong_match_engine_if.slave bus
);
    localparam int HW = $clog2(TOTAL_HEIGHT + 1);
    localparam int WW = $clog2(TOTAL_WIDTH + 1);
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int CW = $clog2(POSITION_CHANGE_FREQ_IN_CLOCKS);
    localparam int DW = $clog2(SERVE_DELAY_TICKS + 1);

    localparam int P1_X = PADDLE_DISTANCE_FROM_EDGE;
    localparam int P2_X = TOTAL_WIDTH - PADDLE_DISTANCE_FROM_EDGE - PADDLE_WIDTH;

    localparam logic [HW-1:0] PY = HW'(TOTAL_HEIGHT / 2 - PADDLE_HEIGHT / 2);
    localparam logic [WW-1:0] BX = WW'(TOTAL_WIDTH / 2 - BALL_SIDE_SIZE / 2);
    localparam logic [HW-1:0] BY = HW'(TOTAL_HEIGHT / 2 - BALL_SIDE_SIZE / 2);

    // One bit wider than the position fields so sums never wrap.
    localparam logic [HW:0] P_MAX = (HW+1)'(TOTAL_HEIGHT - PADDLE_HEIGHT);
    localparam logic [HW:0] P_SPD = (HW+1)'(PADDLE_SPEED);
    localparam logic [HW:0] Y_MAX = (HW+1)'(TOTAL_HEIGHT - BALL_SIDE_SIZE);
    localparam logic [HW:0] Y_SPD = (HW+1)'(BALL_SPEED);
    localparam logic [HW:0] P_HGT = (HW+1)'(PADDLE_HEIGHT);
    localparam logic [HW:0] B_SZ  = (HW+1)'(BALL_SIDE_SIZE);
    localparam logic [WW:0] X_MAX = (WW+1)'(TOTAL_WIDTH - BALL_SIDE_SIZE);
    localparam logic [WW:0] X_SPD = (WW+1)'(BALL_SPEED);
    localparam logic [WW:0] FACE1 = (WW+1)'(P1_X + PADDLE_WIDTH);
    localparam logic [WW:0] FACE2 = (WW+1)'(P2_X - BALL_SIDE_SIZE);

    localparam logic [CW-1:0] TICK_LAST  = CW'(POSITION_CHANGE_FREQ_IN_CLOCKS - 1);
    localparam logic [DW-1:0] SERVE_LAST = DW'(SERVE_DELAY_TICKS - 1);
    localparam logic [SW-1:0] WIN        = SW'(WIN_SCORE);

    typedef enum logic [1:0] {
        SERVE     = 2'b00,
        PLAY      = 2'b01,
        POINT     = 2'b10,
        GAME_OVER = 2'b11
    } state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [DW-1:0] serve_cnt;
    logic [HW-1:0] p1, p2, by;
    logic [WW-1:0] bx;
    logic          dir_x, dir_y;  // 1 = right / down
    logic [SW-1:0] s1, s2;
    logic          win_r, tick_r, scorer;  // scorer 1 = player 2

    function automatic logic [HW-1:0] paddle_next(input logic [HW-1:0] pos,
                                                  input logic up, input logic dn);
        logic [HW:0] lower;
        lower       = {1'b0, pos} + P_SPD;
        paddle_next = pos;
        if (up && !dn)
            paddle_next = ({1'b0, pos} >= P_SPD) ? pos - P_SPD[HW-1:0] : '0;
        else if (dn && !up)
            paddle_next = (lower > P_MAX) ? P_MAX[HW-1:0] : lower[HW-1:0];
    endfunction

    logic          tick_now;
    logic [HW:0]   yw, y_fwd, p1w, p2w;
    logic [WW:0]   xw, x_fwd;
    logic          ov1, ov2, miss, miss_sc, ndx, ndy;
    logic [WW-1:0] nx;
    logic [HW-1:0] ny;
    logic [SW-1:0] sc_new;

    assign tick_now = (tick_cnt == TICK_LAST);
    assign sc_new   = (scorer ? s2 : s1) + SW'(1);

    always_comb begin
        yw      = {1'b0, by};
        xw      = {1'b0, bx};
        p1w     = {1'b0, p1};
        p2w     = {1'b0, p2};
        y_fwd   = yw + Y_SPD;
        x_fwd   = xw + X_SPD;
        ov1     = (yw + B_SZ > p1w) && (yw < p1w + P_HGT);
        ov2     = (yw + B_SZ > p2w) && (yw < p2w + P_HGT);
        ny      = by;
        ndy     = dir_y;
        nx      = bx;
        ndx     = dir_x;
        miss    = 1'b0;
        miss_sc = 1'b0;

        if (dir_y) begin
            if (y_fwd > Y_MAX) begin
                ny  = Y_MAX[HW-1:0];
                ndy = 1'b0;
            end else begin
                ny = y_fwd[HW-1:0];
            end
        end else if (yw < Y_SPD) begin
            ny  = '0;
            ndy = 1'b1;
        end else begin
            ny = by - Y_SPD[HW-1:0];
        end

        // A paddle hit is tested before the miss so it wins on the same tick.
        if (dir_x) begin
            if (xw <= FACE2 && x_fwd >= FACE2 && ov2) begin
                nx  = FACE2[WW-1:0];
                ndx = 1'b0;
            end else if (x_fwd > X_MAX) begin
                nx   = X_MAX[WW-1:0];
                miss = 1'b1;
            end else begin
                nx = x_fwd[WW-1:0];
            end
        end else begin
            if (xw >= FACE1 && xw <= FACE1 + X_SPD && ov1) begin
                nx  = FACE1[WW-1:0];
                ndx = 1'b1;
            end else if (xw < X_SPD) begin
                nx      = '0;
                miss    = 1'b1;
                miss_sc = 1'b1;
            end else begin
                nx = bx - X_SPD[WW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SERVE;
            tick_cnt  <= '0;
            serve_cnt <= '0;
            p1        <= PY;
            p2        <= PY;
            bx        <= BX;
            by        <= BY;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            s1        <= '0;
            s2        <= '0;
            win_r     <= 1'b0;
            tick_r    <= 1'b0;
            scorer    <= 1'b0;
        end else begin
            tick_r   <= tick_now;
            tick_cnt <= tick_now ? '0 : tick_cnt + CW'(1);
            if (state == GAME_OVER) begin
                if (bus.start) begin
                    s1        <= '0;
                    s2        <= '0;
                    p1        <= PY;
                    p2        <= PY;
                    dir_x     <= 1'b1;
                    serve_cnt <= '0;
                    state     <= SERVE;
                end
            end else if (tick_now) begin
                p1 <= paddle_next(p1, bus.button_up_1, bus.button_down_1);
                p2 <= paddle_next(p2, bus.button_up_2, bus.button_down_2);
                case (state)
                    SERVE: begin
                        bx <= BX;
                        by <= BY;
                        if (serve_cnt == SERVE_LAST) begin
                            serve_cnt <= '0;
                            state     <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + DW'(1);
                        end
                    end
                    PLAY: begin
                        bx    <= nx;
                        by    <= ny;
                        dir_x <= ndx;
                        dir_y <= ndy;
                        if (miss) begin
                            scorer <= miss_sc;
                            state  <= POINT;
                        end
                    end
                    POINT: begin
                        bx    <= BX;
                        by    <= BY;
                        // Serve toward whoever conceded the point.
                        dir_x <= ~scorer;
                        if (scorer) s2 <= sc_new;
                        else        s1 <= sc_new;
                        if (sc_new == WIN) begin
                            win_r <= scorer;
                            state <= GAME_OVER;
                        end else begin
                            state <= SERVE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.paddle_1_pos = p1;
    assign bus.paddle_2_pos = p2;
    assign bus.ball_pos_x   = bx;
    assign bus.ball_pos_y   = by;
    assign bus.score_1      = s1;
    assign bus.score_2      = s2;
    assign bus.game_state   = state;
    assign bus.winner       = win_r;
    assign bus.tick         = tick_r;
endmodule

// File: tb/tb_pong_match_engine.sv
// Directed bench for pong_match_engine on a 64x48 field with a 4-clock tick;
// expected positions are hand-traced tick by tick from reset.
module tb_pong_match_engine;
    localparam int F = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors  = 0;
    int   checks  = 0;
    int   tick_no = 0;

    pong_match_engine_if #(.HW(6), .WW(7), .SW(2)) bus ();

    pong_match_engine #(
        .POSITION_CHANGE_FREQ_IN_CLOCKS(F),
        .TOTAL_WIDTH(64),
        .TOTAL_HEIGHT(48),
        .PADDLE_DISTANCE_FROM_EDGE(4),
        .PADDLE_HEIGHT(8),
        .PADDLE_WIDTH(2),
        .BALL_SIDE_SIZE(2),
        .PADDLE_SPEED(2),
        .BALL_SPEED(1),
        .WIN_SCORE(3),
        .SERVE_DELAY_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (tick %0d)", tag, obs, exp, tick_no);
        end
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(bus.ball_pos_x), x);
        chk({tag, "_y"}, 32'(bus.ball_pos_y), y);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_p1"}, 32'(bus.paddle_1_pos), 20);
        chk({tag, "_p2"}, 32'(bus.paddle_2_pos), 20);
        chk_ball(tag, 31, 23);
        chk({tag, "_s1"}, 32'(bus.score_1), 0);
        chk({tag, "_s2"}, 32'(bus.score_2), 0);
        chk({tag, "_state"}, 32'(bus.game_state), 0);
        chk({tag, "_winner"}, 32'(bus.winner), 0);
        chk({tag, "_tick"}, 32'(bus.tick), 0);
    endtask

    // Advance to the next tick pulse, sampled 1 time unit after the edge.
    task automatic step_tick();
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (bus.tick !== 1'b1 && k < 2 * F);
        chk("tick_seen", 32'(bus.tick), 1);
        tick_no++;
    endtask

    task automatic to_tick(input int n);
        while (tick_no < n) step_tick();
    endtask

    initial begin
        bus.button_up_1   = 1'b0;
        bus.button_down_1 = 1'b0;
        bus.button_up_2   = 1'b0;
        bus.button_down_2 = 1'b0;
        bus.start         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");

        rst = 1'b0;
        for (int c = 1; c <= 2 * F; c++) begin
            @(posedge clk);
            #1;
            chk("tick_cycle", 32'(bus.tick), 32'(c % F == 0));
            if (c == F) chk("state_tick1", 32'(bus.game_state), 0);
        end
        tick_no = 2;
        chk("state_tick2", 32'(bus.game_state), 1);
        chk_ball("serve_hold", 31, 23);

        to_tick(3);  chk_ball("launch3", 32, 24);
        to_tick(4);  chk_ball("launch4", 33, 25);

        bus.button_up_1 = 1'b1;
        to_tick(5);  chk("p1_up5", 32'(bus.paddle_1_pos), 18);
        to_tick(6);  chk("p1_up6", 32'(bus.paddle_1_pos), 16);
        to_tick(14); chk("p1_up14", 32'(bus.paddle_1_pos), 0);
        to_tick(16); chk("p1_sat", 32'(bus.paddle_1_pos), 0);
        bus.button_up_1   = 1'b0;
        bus.button_down_2 = 1'b1;
        to_tick(17); chk("p2_dn17", 32'(bus.paddle_2_pos), 22);
        to_tick(25); chk("p2_dn25", 32'(bus.paddle_2_pos), 38);
        chk_ball("bottom_reach", 54, 46);
        to_tick(26); chk("p2_dn26", 32'(bus.paddle_2_pos), 40);
        chk_ball("bottom_clamp", 55, 46);
        to_tick(27); chk_ball("p2_hit", 56, 45);
        to_tick(28); chk_ball("after_hit", 55, 44);
        to_tick(36); chk("p2_sat", 32'(bus.paddle_2_pos), 40);
        bus.button_down_2 = 1'b0;

        to_tick(50);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("start_ignored", 32'(bus.game_state), 1);

        to_tick(72); chk_ball("top_reach", 11, 0);
        to_tick(73); chk_ball("top_clamp", 10, 0);
        to_tick(74); chk_ball("top_bounce", 9, 1);
        to_tick(77); chk_ball("p1_hit", 6, 4);
        to_tick(78); chk_ball("after_p1_hit", 7, 5);

        to_tick(79);
        bus.button_up_2 = 1'b1;
        to_tick(84); chk("p2_up84", 32'(bus.paddle_2_pos), 30);
        to_tick(89); chk("p2_up89", 32'(bus.paddle_2_pos), 20);
        bus.button_down_2 = 1'b1;
        to_tick(93); chk("p2_both", 32'(bus.paddle_2_pos), 20);
        bus.button_up_2   = 1'b0;
        bus.button_down_2 = 1'b0;

        to_tick(127); chk_ball("p2_pass", 56, 39);
        to_tick(133); chk_ball("edge_reach", 62, 33);
        chk("state_edge", 32'(bus.game_state), 1);
        to_tick(134); chk_ball("miss1", 62, 32);
        chk("state_point", 32'(bus.game_state), 2);
        chk("s1_before", 32'(bus.score_1), 0);
        to_tick(135); chk("s1_pt1", 32'(bus.score_1), 1);
        chk("s2_pt1", 32'(bus.score_2), 0);
        chk("state_serve1", 32'(bus.game_state), 0);
        chk_ball("recentre1", 31, 23);
        to_tick(137); chk("state_play2", 32'(bus.game_state), 1);
        // Player 1 scored, so the serve heads right toward player 2.
        to_tick(138); chk_ball("serve_dir", 32, 22);

        to_tick(162); chk_ball("miss2_path", 56, 1);
        to_tick(169); chk("state_point2", 32'(bus.game_state), 2);
        chk_ball("miss2", 62, 8);
        to_tick(170); chk("s1_pt2", 32'(bus.score_1), 2);
        chk("state_serve2", 32'(bus.game_state), 0);

        to_tick(173); chk_ball("launch3rd", 32, 24);
        to_tick(196); chk_ball("bottom3", 55, 46);
        to_tick(204); chk("state_point3", 32'(bus.game_state), 2);
        chk_ball("miss3", 62, 38);
        to_tick(205); chk("s1_win", 32'(bus.score_1), 3);
        chk("state_over", 32'(bus.game_state), 3);
        chk("winner", 32'(bus.winner), 0);
        chk_ball("over_ball", 31, 23);

        bus.button_down_1 = 1'b1;
        bus.button_up_2   = 1'b1;
        to_tick(207);
        chk("frozen_p1", 32'(bus.paddle_1_pos), 0);
        chk("frozen_p2", 32'(bus.paddle_2_pos), 20);
        chk_ball("frozen_ball", 31, 23);
        chk("frozen_state", 32'(bus.game_state), 3);
        bus.button_down_1 = 1'b0;
        bus.button_up_2   = 1'b0;

        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("restart_s1", 32'(bus.score_1), 0);
        chk("restart_s2", 32'(bus.score_2), 0);
        chk("restart_state", 32'(bus.game_state), 0);
        chk("restart_p1", 32'(bus.paddle_1_pos), 20);
        to_tick(208); chk("restart_serve", 32'(bus.game_state), 0);
        to_tick(209); chk("restart_play", 32'(bus.game_state), 1);
        to_tick(210); chk_ball("restart_launch", 32, 22);

        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        @(posedge clk);
        #1;
        chk_reset_values("held_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
